hazard_controller: RTL

Pipeline sequencing unit for the five-stage RV64 core. It decides, every cycle, whether each pipeline register loads, holds, or is flushed to a bubble. Its inputs are load-use hazards, taken branches resolved in EX/MEM, and a multi-cycle data-memory busy level. Because the ID/EX register has no reset of its own, the controller also flushes the pipeline for a fixed number of cycles after reset, and it keeps saturating stall, flush and wait statistics.

---
 rtl/hazard_controller_pkg.sv | 14 +
 rtl/hazard_controller.sv | 126 ++++++++++++
 2 files changed

// File: rtl/hazard_controller_pkg.sv
// rtl/hazard_controller_pkg.sv - shared types for the pipeline hazard controller
package hazard_controller_pkg;

  typedef enum logic [1:0] {
    INIT = 2'd0,
    RUN  = 2'd1,
    WAIT = 2'd2
  } state_t;

  typedef logic [4:0] reg_idx_t;

  localparam reg_idx_t X0 = 5'd0;

endpackage

// File: rtl/hazard_controller.sv
// rtl/hazard_controller.sv - per-cycle load/hold/flush sequencing for the five-stage pipeline
module hazard_controller
  import hazard_controller_pkg::*;
#(
  parameter int INIT_CYCLES = 3,
  parameter int MEM_TIMEOUT = 255,
  parameter int STAT_W      = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  reg_idx_t          IFID_Rs1,
  input  reg_idx_t          IFID_Rs2,
  input  logic              IFID_Uses_Rs1,
  input  logic              IFID_Uses_Rs2,
  input  logic              IDEX_MemRead,
  input  reg_idx_t          IDEX_Rd,
  input  logic              Branch_Taken,
  input  logic              Mem_Busy,
  output logic              PC_Write,
  output logic              PC_Src,
  output logic              IFID_Write,
  output logic              IFID_Flush,
  output logic              IDEX_Flush,
  output logic              EXMEM_Flush,
  output logic              Pipe_Freeze,
  output logic              Mem_Timeout,
  output logic [STAT_W-1:0] Stall_Count,
  output logic [STAT_W-1:0] Flush_Count,
  output logic [STAT_W-1:0] Wait_Count
);

  localparam int IW = (INIT_CYCLES < 2) ? 1 : $clog2(INIT_CYCLES + 1);
  localparam int BW = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam logic [BW-1:0] BUSY_MAX = BW'(MEM_TIMEOUT);
  localparam logic [BW-1:0] BUSY_TRIP = BW'(MEM_TIMEOUT - 1);

  state_t          state;
  state_t          next_state;
  logic [IW-1:0]   init_cnt;
  logic [BW-1:0]   busy_run;
  logic            load_use;
  logic            do_stall;
  logic            do_flush;
  logic            do_wait;

  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
    return (&v) ? v : v + STAT_W'(1);
  endfunction

  assign load_use = IDEX_MemRead && (IDEX_Rd != X0) &&
                    (((IDEX_Rd == IFID_Rs1) && IFID_Uses_Rs1) ||
                     ((IDEX_Rd == IFID_Rs2) && IFID_Uses_Rs2));

  // RUN and WAIT share one priority decode; WAIT only differs in entering from a busy cycle.
  always_comb begin
    next_state  = state;
    PC_Write    = 1'b0;
    PC_Src      = 1'b0;
    IFID_Write  = 1'b0;
    IFID_Flush  = 1'b0;
    IDEX_Flush  = 1'b0;
    EXMEM_Flush = 1'b0;
    Pipe_Freeze = 1'b0;
    do_stall    = 1'b0;
    do_flush    = 1'b0;
    do_wait     = 1'b0;
    case (state)
      INIT: begin
        IFID_Flush  = 1'b1;
        IDEX_Flush  = 1'b1;
        EXMEM_Flush = 1'b1;
        if (init_cnt <= IW'(1)) next_state = RUN;
      end
      default: begin
        if (Mem_Busy) begin
          Pipe_Freeze = 1'b1;
          do_wait     = 1'b1;
          next_state  = WAIT;
        end else begin
          next_state = RUN;
          if (Branch_Taken) begin
            PC_Write    = 1'b1;
            PC_Src      = 1'b1;
            IFID_Write  = 1'b1;
            IFID_Flush  = 1'b1;
            IDEX_Flush  = 1'b1;
            EXMEM_Flush = 1'b1;
            do_flush    = 1'b1;
          end else if (load_use) begin
            IDEX_Flush = 1'b1;
            do_stall   = 1'b1;
          end else begin
            PC_Write   = 1'b1;
            IFID_Write = 1'b1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= INIT;
      init_cnt    <= IW'(INIT_CYCLES);
      busy_run    <= '0;
      Mem_Timeout <= 1'b0;
      Stall_Count <= '0;
      Flush_Count <= '0;
      Wait_Count  <= '0;
    end else begin
      state <= next_state;
      if ((state == INIT) && (init_cnt > IW'(1))) init_cnt <= init_cnt - IW'(1);
      // busy_run counts the current busy cycle, so the flag trips on the edge ending busy cycle MEM_TIMEOUT
      if (do_wait) begin
        Wait_Count <= sat_inc(Wait_Count);
        if (busy_run != BUSY_MAX) busy_run <= busy_run + BW'(1);
        if (busy_run >= BUSY_TRIP) Mem_Timeout <= 1'b1;
      end else begin
        busy_run <= '0;
      end
      if (do_stall) Stall_Count <= sat_inc(Stall_Count);
      if (do_flush) Flush_Count <= sat_inc(Flush_Count);
    end
  end

endmodule
